// File: rtl/feed_decoder.sv
// Framed byte-stream decoder: turns fixed 10-byte add/delete messages into
// single-cycle tick pulses, dropping malformed frames and counting good/bad frames.
module feed_decoder #(
  parameter int         CNT_W    = 16,
  parameter logic [7:0] TYPE_ADD = 8'h41,
  parameter logic [7:0] TYPE_DEL = 8'h44
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             tick_valid,
  output logic             tick_type,
  output logic             tick_side,
  output logic [31:0]      tick_qty,
  output logic [31:0]      tick_price,
  output logic [CNT_W-1:0] msg_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [7:0] SIDE_BID = 8'h42;
  localparam logic [7:0] SIDE_ASK = 8'h53;

  typedef enum logic [1:0] {IDLE, BODY, DISCARD} state_t;

  state_t             state_q, state_d;
  logic [3:0]         idx_q, idx_d;
  logic               type_q, type_d;
  logic               side_q, side_d;
  logic [63:0]        payload_q, payload_d;
  logic               s_ready_q, s_ready_d;
  logic               tick_valid_q, tick_valid_d;
  logic               tick_type_q, tick_type_d;
  logic               tick_side_q, tick_side_d;
  logic [31:0]        tick_qty_q, tick_qty_d;
  logic [31:0]        tick_price_q, tick_price_d;
  logic [CNT_W-1:0]   msg_cnt_q, msg_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  logic        accept;
  logic        err;
  logic        emit;
  logic        side_ok;
  logic [63:0] payload_next;

  assign accept       = s_valid && s_ready_q;
  // Bytes 2..9 shift in big-endian, so after byte 9 qty sits in [63:32] and price in [31:0].
  assign payload_next = {payload_q[55:0], s_data};

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    type_d       = type_q;
    side_d       = side_q;
    payload_d    = payload_q;
    s_ready_d    = 1'b1;
    tick_valid_d = 1'b0;
    tick_type_d  = tick_type_q;
    tick_side_d  = tick_side_q;
    tick_qty_d   = tick_qty_q;
    tick_price_d = tick_price_q;
    msg_cnt_d    = msg_cnt_q;
    err_cnt_d    = err_cnt_q;
    err          = 1'b0;
    emit         = 1'b0;
    side_ok      = (s_data == SIDE_BID) || (s_data == SIDE_ASK);

    if (accept) begin
      case (state_q)
        IDLE: begin
          if ((s_data == TYPE_ADD) || (s_data == TYPE_DEL)) begin
            type_d = (s_data == TYPE_DEL);
            if (s_last) begin
              err = 1'b1;
            end else begin
              state_d = BODY;
              idx_d   = 4'd1;
            end
          end else begin
            err = 1'b1;
          end
        end
        BODY: begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd1) begin
            side_d = (s_data == SIDE_BID);
          end else begin
            payload_d = payload_next;
          end
          if ((idx_q == 4'd1) && !side_ok) begin
            err = 1'b1;
          end else if (idx_q == 4'd9) begin
            if (s_last) emit = 1'b1;
            else        err  = 1'b1;
          end else if (s_last) begin
            err = 1'b1;
          end
        end
        DISCARD: begin
          if (s_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      // One error per frame; resync immediately if the offending byte closes the frame.
      if (err) begin
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        state_d = s_last ? IDLE : DISCARD;
        idx_d   = 4'd0;
      end

      if (emit) begin
        state_d      = IDLE;
        idx_d        = 4'd0;
        tick_valid_d = 1'b1;
        tick_type_d  = type_q;
        tick_side_d  = side_q;
        tick_qty_d   = payload_next[63:32];
        tick_price_d = payload_next[31:0];
        if (msg_cnt_q != {CNT_W{1'b1}}) msg_cnt_d = msg_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      idx_q        <= 4'd0;
      type_q       <= 1'b0;
      side_q       <= 1'b0;
      payload_q    <= 64'd0;
      s_ready_q    <= 1'b0;
      tick_valid_q <= 1'b0;
      tick_type_q  <= 1'b0;
      tick_side_q  <= 1'b0;
      tick_qty_q   <= 32'd0;
      tick_price_q <= 32'd0;
      msg_cnt_q    <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      type_q       <= type_d;
      side_q       <= side_d;
      payload_q    <= payload_d;
      s_ready_q    <= s_ready_d;
      tick_valid_q <= tick_valid_d;
      tick_type_q  <= tick_type_d;
      tick_side_q  <= tick_side_d;
      tick_qty_q   <= tick_qty_d;
      tick_price_q <= tick_price_d;
      msg_cnt_q    <= msg_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign s_ready    = s_ready_q;
  assign tick_valid = tick_valid_q;
  assign tick_type  = tick_type_q;
  assign tick_side  = tick_side_q;
  assign tick_qty   = tick_qty_q;
  assign tick_price = tick_price_q;
  assign msg_cnt    = msg_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_feed_decoder.sv
// Scoreboard bench for feed_decoder: expected ticks are queued as frames are driven
// and matched (values and arrival cycle) whenever tick_valid pulses.
module tb_feed_decoder;

  localparam int CNT_W = 4;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       s_data = 8'h00;
  logic             s_valid = 1'b0;
  logic             s_last = 1'b0;
  logic             s_ready;
  logic             tick_valid;
  logic             tick_type;
  logic             tick_side;
  logic [31:0]      tick_qty;
  logic [31:0]      tick_price;
  logic [CNT_W-1:0] msg_cnt;
  logic [CNT_W-1:0] err_cnt;

  typedef struct {
    logic        typ;
    logic        side;
    logic [31:0] qty;
    logic [31:0] price;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         exp_msg = 0;
  int         exp_err = 0;
  logic [7:0] raw [16];

  feed_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .tick_valid(tick_valid), .tick_type(tick_type),
    .tick_side(tick_side), .tick_qty(tick_qty), .tick_price(tick_price),
    .msg_cnt(msg_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every pulse must match the oldest queued frame, both in content and arrival cycle.
  always @(negedge clk) begin
    if (tick_valid) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_tick got type=%0b side=%0b qty=%0d price=%0d required none",
                 tick_type, tick_side, tick_qty, tick_price);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({tick_type, tick_side, tick_qty, tick_price} !== {e.typ, e.side, e.qty, e.price}
            || cyc != e.cyc) begin
          failures++;
          $display("[TB] FAIL tick got type=%0b side=%0b qty=%0d price=%0d cyc=%0d required type=%0b side=%0b qty=%0d price=%0d cyc=%0d",
                   tick_type, tick_side, tick_qty, tick_price, cyc,
                   e.typ, e.side, e.qty, e.price, e.cyc);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] d, input logic last);
    s_data  = d;
    s_last  = last;
    s_valid = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input int n, input int last_at);
    for (int i = 0; i < n; i++) send_byte(raw[i], i == last_at);
  endtask

  task automatic send_frame(input logic [7:0] typ, input logic [7:0] side,
                            input logic [31:0] qty, input logic [31:0] price,
                            input bit good, input bit stall);
    logic [7:0] b [10];
    exp_t e;
    b[0] = typ; b[1] = side;
    for (int i = 0; i < 4; i++) begin
      b[2+i] = qty[31-8*i -: 8];
      b[6+i] = price[31-8*i -: 8];
    end
    for (int i = 0; i < 10; i++) begin
      send_byte(b[i], i == 9);
      if (stall && i < 9) idle_cycle();
    end
    if (good) begin
      e.typ = (typ == 8'h44); e.side = (side == 8'h42);
      e.qty = qty; e.price = price; e.cyc = cyc;
      sb.push_back(e);
      if (exp_msg < MAXC) exp_msg++;
    end else if (exp_err < MAXC) begin
      exp_err++;
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) idle_cycle();
    checks++;
    if ({s_ready, tick_valid, tick_type, tick_side, tick_qty, tick_price, msg_cnt, err_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ready=%0b valid=%0b qty=%0d price=%0d msg=%0d err=%0d required all 0",
               s_ready, tick_valid, tick_qty, tick_price, msg_cnt, err_cnt);
    end
    rst = 1'b0;
    idle_cycle();
    checks++;
    if (s_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL ready_after_reset got %0b required 1", s_ready);
    end
  endtask

  task automatic test_single_add();
    send_frame(8'h41, 8'h42, 32'd10, 32'd10000, 1, 0);
    wait_drain();
    checks++;
    if (sb.size() != 0 || msg_cnt !== 4'(exp_msg) || err_cnt !== 4'(exp_err)) begin
      failures++;
      $display("[TB] FAIL single_add pending=%0d msg=%0d err=%0d required pending=0 msg=%0d err=%0d",
               sb.size(), msg_cnt, err_cnt, exp_msg, exp_err);
    end
  endtask

  task automatic test_back_to_back();
    send_frame(8'h41, 8'h53, 32'd5, 32'd10010, 1, 0);
    send_frame(8'h41, 8'h42, 32'd20, 32'd10005, 1, 0);
    wait_drain();
    checks++;
    if (sb.size() != 0 || msg_cnt !== 4'(exp_msg)) begin
      failures++;
      $display("[TB] FAIL back_to_back pending=%0d msg=%0d required pending=0 msg=%0d",
               sb.size(), msg_cnt, exp_msg);
    end
  endtask

  task automatic test_stall();
    send_frame(8'h44, 8'h53, 32'd5, 32'd10010, 1, 1);
    wait_drain();
    repeat (3) idle_cycle();
    checks++;
    if (sb.size() != 0 || msg_cnt !== 4'(exp_msg) || tick_valid !== 1'b0
        || tick_type !== 1'b1 || tick_qty !== 32'd5 || tick_price !== 32'd10010) begin
      failures++;
      $display("[TB] FAIL stall_hold pending=%0d msg=%0d valid=%0b type=%0b qty=%0d price=%0d required pending=0 msg=%0d valid=0 type=1 qty=5 price=10010",
               sb.size(), msg_cnt, tick_valid, tick_type, tick_qty, tick_price, exp_msg);
    end
  endtask

  task automatic test_bad_type();
    send_frame(8'h58, 8'h42, 32'd7, 32'd10001, 0, 0);
    send_frame(8'h41, 8'h53, 32'd3, 32'd10020, 1, 0);
    wait_drain();
    checks++;
    if (sb.size() != 0 || msg_cnt !== 4'(exp_msg) || err_cnt !== 4'(exp_err)) begin
      failures++;
      $display("[TB] FAIL bad_type pending=%0d msg=%0d err=%0d required pending=0 msg=%0d err=%0d",
               sb.size(), msg_cnt, err_cnt, exp_msg, exp_err);
    end
  endtask

  task automatic test_runt_overlong();
    for (int i = 0; i < 16; i++) raw[i] = 8'(i);
    raw[0] = 8'h41; raw[1] = 8'h42;
    send_raw(5, 4);
    exp_err++;
    send_raw(12, 11);
    exp_err++;
    raw[1] = 8'h58;
    send_raw(10, 9);
    exp_err++;
    send_frame(8'h44, 8'h42, 32'd0, 32'd0, 1, 0);
    wait_drain();
    checks++;
    if (sb.size() != 0 || msg_cnt !== 4'(exp_msg) || err_cnt !== 4'(exp_err)) begin
      failures++;
      $display("[TB] FAIL runt_overlong pending=%0d msg=%0d err=%0d required pending=0 msg=%0d err=%0d",
               sb.size(), msg_cnt, err_cnt, exp_msg, exp_err);
    end
  endtask

  task automatic test_reset_mid_frame();
    raw[0] = 8'h41; raw[1] = 8'h42;
    for (int i = 2; i < 6; i++) raw[i] = 8'hA0;
    send_raw(6, -1);
    rst = 1'b1;
    idle_cycle();
    exp_msg = 0;
    exp_err = 0;
    checks++;
    if (msg_cnt !== 4'd0 || err_cnt !== 4'd0 || s_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_reset got msg=%0d err=%0d ready=%0b required 0 0 0",
               msg_cnt, err_cnt, s_ready);
    end
    rst = 1'b0;
    idle_cycle();
    send_frame(8'h41, 8'h53, 32'd42, 32'd9999, 1, 0);
    wait_drain();
    checks++;
    if (sb.size() != 0 || msg_cnt !== 4'd1 || err_cnt !== 4'd0) begin
      failures++;
      $display("[TB] FAIL after_mid_reset pending=%0d msg=%0d err=%0d required pending=0 msg=1 err=0",
               sb.size(), msg_cnt, err_cnt);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < MAXC + 2; i++) begin
      send_byte(8'h41, 1'b1);
      if (exp_err < MAXC) exp_err++;
    end
    checks++;
    if (err_cnt !== 4'(MAXC) || msg_cnt !== 4'(exp_msg)) begin
      failures++;
      $display("[TB] FAIL err_saturate got err=%0d msg=%0d required err=%0d msg=%0d",
               err_cnt, msg_cnt, MAXC, exp_msg);
    end
    for (int i = 0; i < MAXC + 1; i++)
      send_frame(8'h41, 8'h42, 32'(i + 1), 32'(20000 + i), 1, 0);
    wait_drain();
    checks++;
    if (sb.size() != 0 || msg_cnt !== 4'(MAXC) || err_cnt !== 4'(MAXC)) begin
      failures++;
      $display("[TB] FAIL msg_saturate pending=%0d msg=%0d err=%0d required pending=0 msg=%0d err=%0d",
               sb.size(), msg_cnt, err_cnt, MAXC, MAXC);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_stall();
    test_bad_type();
    test_runt_overlong();
    test_reset_mid_frame();
    test_saturation();
    repeat (3) idle_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
